instr_queue: RTL and testbench
==============================

// Module: instr_queue
// PURPOSE
//  Parametrised successor of the single-entry instruction register: DEPTH-entry
//  FIFO of fetched instructions with valid/ready handshake on both sides.
//  Sits between instruction memory fetch and the control unit.
//  Presents head instruction pre-split into opcode/rx/ry fields.
//  Flush discards queued instructions on a control-flow change.
// PARAMETERS
//  WIDTH   10  instruction width in bits
//  DEPTH   4   number of entries, >=1, need not be a power of two
//  OPC_W   4   opcode field width, taken from MSBs [WIDTH-1 -: OPC_W]
//  REG_W   3   register-field width; rx=[2*REG_W-1:REG_W], ry=[REG_W-1:0]
// PORTS
//  clock       in   1                   rising-edge clock
//  resetn      in   1                   synchronous reset, active low
//  in          in   WIDTH               instruction from fetch
//  in_valid    in   1                   'in' holds a valid instruction
//  in_ready    out  1                   queue accepts 'in' this cycle
//  flush       in   1                   discard all entries
//  out         out  WIDTH               head instruction (0 when empty)
//  out_valid   out  1                   head is valid
//  out_ready   in   1                   consumer takes head this cycle
//  opcode      out  OPC_W               out[WIDTH-1 -: OPC_W]
//  rx          out  REG_W               out[2*REG_W-1:REG_W]
//  ry          out  REG_W               out[REG_W-1:0]
//  count       out  $clog2(DEPTH+1)     occupied entries
// BEHAVIOUR
//  - One clock (clock); reset synchronous, active low (resetn).
//  - Reset (resetn=0 at posedge): wr_ptr=rd_ptr=0, count=0, out_valid=0,
//    out=0, in_ready=1. Storage contents not cleared. Reset mid-transfer
//    drops any push/pop of that cycle.
//  - push = in_valid & in_ready; pop = out_valid & out_ready.
//  - in_ready = (count != DEPTH), combinational from count only; no bypass,
//    so a full queue refuses a push even if pop occurs that cycle.
//  - out_valid = (count != 0); out/opcode/rx/ry combinational from
//    storage[rd_ptr], forced to 0 when empty.
//  - Latency: instruction pushed at edge N is visible on out after edge N
//    (usable in cycle N+1). Empty queue never passes in to out combinationally.
//  - Push+pop same cycle (not full, not empty): both pointers advance,
//    count unchanged.
//  - Pointers wrap DEPTH-1 -> 0 explicitly (non-power-of-two DEPTH legal).
//  - flush=1: next state wr_ptr=rd_ptr=0, count=0; overrides push and pop
//    in same cycle (incoming instruction dropped). resetn has priority over flush.
//  - Push while full / pop while empty are impossible by handshake; state
//    unchanged if in_valid=1 at full or out_ready=1 at empty.
//  - DEPTH=1 degenerates to a handshaked version of the single-entry register.
// STRUCTURE
//  - Shared package (cpu_pkg): INSTR_W=10, OPC_W=4, REG_W=3, field MSB/LSB
//    localparams, opcode constants. Control unit uses the same definitions.
//  - Sub-module instr_fields (combinational WIDTH -> opcode/rx/ry split),
//    reused by the decoder.
//  - Core: storage array, two pointers, counter, one always @(posedge clock)
//    block for state.
// TESTING
//  1 resetn=0 for 2 cycles -> count=0, out_valid=0, out=0, in_ready=1.
//  2 Push 10'h2A5 into empty -> next cycle out=10'h2A5, opcode=4'hA,
//    rx=3'h4, ry=3'h5, count=1.
//  3 Push 4 (DEPTH=4) with out_ready=0 -> in_ready=0 at count=4; 5th push
//    ignored; pop all 4 -> FIFO order, count=0.
//  4 Full with simultaneous in_valid/out_ready -> pop only, count 4->3.
//    Half full with push+pop -> count constant across 10 cycles, order kept
//    across pointer wrap.
//  5 flush=1 with count=3 and in_valid=1 -> next cycle count=0,
//    out_valid=0, pushed word absent.
//  6 DEPTH=3 build: 7 push/pop pairs -> pointers wrap 2->0, data order
//    correct; resetn=0 with push active -> count=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction geometry and opcode encodings.
// Used by the instruction queue, field splitter and the control unit decoder.
package cpu_pkg;

    localparam int INSTR_W = 10;
    localparam int OPC_W   = 4;
    localparam int REG_W   = 3;

    localparam int OPC_MSB = INSTR_W - 1;
    localparam int OPC_LSB = INSTR_W - OPC_W;
    localparam int RX_MSB  = 2*REG_W - 1;
    localparam int RX_LSB  = REG_W;
    localparam int RY_MSB  = REG_W - 1;
    localparam int RY_LSB  = 0;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP  = 4'h0,
        OP_MV   = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_LD   = 4'h8,
        OP_ST   = 4'h9,
        OP_MVI  = 4'hA,
        OP_BR   = 4'hC,
        OP_HALT = 4'hF
    } opcode_t;

endpackage

// File: rtl/instr_fields.sv
// Splits an instruction word into opcode / rx / ry fields.
// Latency: combinational. Backpressure: none (pure function of the input).
// Shared with the control-unit decoder so both agree on field placement.
module instr_fields #(
    parameter int WIDTH = cpu_pkg::INSTR_W,
    parameter int OPC_W = cpu_pkg::OPC_W,
    parameter int REG_W = cpu_pkg::REG_W
) (
    input  logic [WIDTH-1:0] instr,
    output logic [OPC_W-1:0] opcode,
    output logic [REG_W-1:0] rx,
    output logic [REG_W-1:0] ry
);

    assign opcode = instr[WIDTH-1 -: OPC_W];
    assign rx     = instr[2*REG_W-1 -: REG_W];
    assign ry     = instr[REG_W-1:0];

endmodule

// File: rtl/instr_queue.sv
// DEPTH-entry instruction FIFO between fetch and control, head pre-split into fields.
// Latency: word pushed at edge N appears on out after edge N; no empty bypass.
// Backpressure: in_ready drops at full (even if popping); flush empties the queue.
module instr_queue #(
    parameter int WIDTH = cpu_pkg::INSTR_W,
    parameter int DEPTH = 4,
    parameter int OPC_W = cpu_pkg::OPC_W,
    parameter int REG_W = cpu_pkg::REG_W
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [WIDTH-1:0]           in,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       flush,
    output logic [WIDTH-1:0]           out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OPC_W-1:0]           opcode,
    output logic [REG_W-1:0]           rx,
    output logic [REG_W-1:0]           ry,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             push;
    logic             pop;

    // Explicit wrap keeps non-power-of-two depths legal.
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = (cnt != FULL);
    assign out_valid = (cnt != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = cnt;
    assign out       = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= nxt(rd_ptr);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    instr_fields #(
        .WIDTH (WIDTH),
        .OPC_W (OPC_W),
        .REG_W (REG_W)
    ) u_fields (
        .instr  (out),
        .opcode (opcode),
        .rx     (rx),
        .ry     (ry)
    );

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue at DEPTH=4 and DEPTH=3.
module tb_instr_queue;

    logic       clock = 1'b0;
    int         total = 0;
    int         bad   = 0;

    // DEPTH=4 instance
    logic       rn4, iv4, fl4, or4;
    logic [9:0] in4;
    logic       ir4, ov4;
    logic [9:0] out4;
    logic [3:0] opc4;
    logic [2:0] rx4, ry4;
    logic [2:0] cnt4;

    // DEPTH=3 instance
    logic       rn3, iv3, fl3, or3;
    logic [9:0] in3;
    logic       ir3, ov3;
    logic [9:0] out3;
    logic [3:0] opc3;
    logic [2:0] rx3, ry3;
    logic [1:0] cnt3;

    logic [9:0] q[$];

    always #5 clock = ~clock;

    instr_queue #(.WIDTH(10), .DEPTH(4), .OPC_W(4), .REG_W(3)) dut4 (
        .clock(clock), .resetn(rn4), .in(in4), .in_valid(iv4), .in_ready(ir4),
        .flush(fl4), .out(out4), .out_valid(ov4), .out_ready(or4),
        .opcode(opc4), .rx(rx4), .ry(ry4), .count(cnt4)
    );

    instr_queue #(.WIDTH(10), .DEPTH(3), .OPC_W(4), .REG_W(3)) dut3 (
        .clock(clock), .resetn(rn3), .in(in3), .in_valid(iv3), .in_ready(ir3),
        .flush(fl3), .out(out3), .out_valid(ov3), .out_ready(or3),
        .opcode(opc3), .rx(rx3), .ry(ry3), .count(cnt3)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rn4 = 0; iv4 = 0; fl4 = 0; or4 = 0; in4 = '0;
        rn3 = 0; iv3 = 0; fl3 = 0; or3 = 0; in3 = '0;

        // 1: reset
        tick(); tick();
        chk("rst_count", cnt4, 0);
        chk("rst_ovalid", ov4, 0);
        chk("rst_out", out4, 0);
        chk("rst_iready", ir4, 1);
        chk("rst3_count", cnt3, 0);
        rn4 = 1; rn3 = 1;

        // 2: single push, field split
        chk("empty_no_bypass_pre", out4, 0);
        iv4 = 1; in4 = 10'h2A5;
        #1 chk("empty_no_bypass", out4, 0);
        tick();
        iv4 = 0;
        chk("p1_out", out4, 10'h2A5);
        chk("p1_opcode", opc4, 4'hA);
        chk("p1_rx", rx4, 3'h4);
        chk("p1_ry", ry4, 3'h5);
        chk("p1_count", cnt4, 1);
        chk("p1_ovalid", ov4, 1);
        or4 = 1;
        tick();
        or4 = 0;
        chk("p1_drained", cnt4, 0);
        chk("p1_out_zero", out4, 0);

        // 3: fill, refused push, drain in order
        for (int i = 0; i < 4; i++) begin
            iv4 = 1; in4 = 10'h100 + 10'(i);
            tick();
        end
        chk("full_count", cnt4, 4);
        chk("full_iready", ir4, 0);
        in4 = 10'h3FF;
        tick();
        iv4 = 0;
        chk("full_push_ignored_cnt", cnt4, 4);
        chk("full_push_ignored_head", out4, 10'h100);
        or4 = 1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", out4, 32'h100 + i);
            tick();
        end
        or4 = 0;
        chk("drain_count", cnt4, 0);
        chk("drain_ovalid", ov4, 0);
        or4 = 1;
        tick();
        or4 = 0;
        chk("pop_empty_count", cnt4, 0);

        // 4: full with push+pop -> pop only; steady half-full streaming
        for (int i = 0; i < 4; i++) begin
            iv4 = 1; in4 = 10'h040 + 10'(i);
            q.push_back(10'h040 + 10'(i));
            tick();
        end
        iv4 = 1; in4 = 10'h3EE; or4 = 1;
        chk("full_pp_iready", ir4, 0);
        tick();
        void'(q.pop_front());
        chk("full_pp_count", cnt4, 3);
        chk("full_pp_head", out4, 10'h041);
        iv4 = 0;
        tick();
        void'(q.pop_front());
        or4 = 0;
        chk("half_count", cnt4, 2);
        iv4 = 1; or4 = 1;
        for (int k = 0; k < 10; k++) begin
            in4 = 10'h080 + 10'(k);
            chk("stream_head", out4, q[0]);
            q.push_back(in4);
            void'(q.pop_front());
            tick();
            chk("stream_count", cnt4, 2);
        end
        iv4 = 0; or4 = 0;
        chk("stream_tail_head", out4, 10'h088);

        // 5: flush overrides push
        iv4 = 1; in4 = 10'h0C1;
        tick();
        chk("preflush_count", cnt4, 3);
        fl4 = 1; in4 = 10'h155;
        tick();
        fl4 = 0; iv4 = 0;
        chk("flush_count", cnt4, 0);
        chk("flush_ovalid", ov4, 0);
        chk("flush_out", out4, 0);
        tick();
        chk("flush_word_absent", cnt4, 0);
        iv4 = 1; in4 = 10'h0DD;
        tick();
        iv4 = 0;
        chk("postflush_head", out4, 10'h0DD);
        chk("postflush_count", cnt4, 1);

        // 6: DEPTH=3 wrap and reset mid-push
        q.delete();
        for (int i = 0; i < 2; i++) begin
            iv3 = 1; in3 = 10'h300 + 10'(i);
            q.push_back(in3);
            tick();
        end
        or3 = 1;
        for (int k = 0; k < 7; k++) begin
            in3 = 10'h310 + 10'(k);
            chk("d3_head", out3, q[0]);
            q.push_back(in3);
            void'(q.pop_front());
            tick();
        end
        or3 = 0;
        chk("d3_count", cnt3, 2);
        chk("d3_head_final", out3, 10'h315);
        iv3 = 1; in3 = 10'h300;
        tick();
        chk("d3_full", ir3, 0);
        in3 = 10'h3AA; rn3 = 0;
        tick();
        rn3 = 1; iv3 = 0;
        chk("d3_rst_count", cnt3, 0);
        chk("d3_rst_ovalid", ov3, 0);
        chk("d3_rst_iready", ir3, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
